// File: rtl/sequenciador_bombas.sv
// Supervisory sequencer for the two-tank pump station.
// Debounces the four level sensors, derives fill demands for motor 1 (lower tank) and
// motor 2 (lower -> upper tank), enforces a restart lockout, and latches sensor
// inconsistency / fill timeout faults until acknowledged.
// Optional build macro: START_STAGGER_EN delays m2 starts relative to m1 starts.
module sequenciador_bombas #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned MIN_OFF    = 8,
   parameter int unsigned MAX_FILL   = 200,
   parameter int unsigned STAGGER    = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s1,
   input  logic       s2,
   input  logic       s3,
   input  logic       s4,
   input  logic       ack,
   output logic       m1,
   output logic       m2,
   output logic       fault,
   output logic [1:0] fault_code
);

   typedef enum logic [1:0] {StOff, StRun, StHold} motor_state_e;

   localparam logic [CNT_W-1:0] One      = CNT_W'(1);
   localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] OffLast  = CNT_W'(MIN_OFF - 1);
   localparam logic [CNT_W-1:0] FillLast = CNT_W'(MAX_FILL - 1);
   // Every counter limit must be representable in CNT_W bits.
   localparam bit CntWOk = ((DEB_CYCLES | MIN_OFF | MAX_FILL | STAGGER) >> CNT_W) == 0;

   logic [3:0]       raw;
   logic [3:0]       filt_q;
   logic [CNT_W-1:0] deb_cnt_q [4];
   logic             f1, f2, f3, f4;
   logic             inv, d1, d2;
   logic             timeout;
   logic             hold_all;
   logic             m2_allow;

   motor_state_e     st1_q, st2_q;
   logic [CNT_W-1:0] off_cnt1_q, off_cnt2_q;
   logic [CNT_W-1:0] fill_cnt_q;

   assign raw = {s4, s3, s2, s1};
   assign f1  = filt_q[0];
   assign f2  = filt_q[1];
   assign f3  = filt_q[2];
   assign f4  = filt_q[3];

   assign inv = (f2 & ~f1) | (f4 & ~f3);
   assign d1  = ~f2;
   assign d2  = f1 & ~f4;

   assign timeout  = (st1_q == StRun) && (fill_cnt_q == FillLast);
   // Any latched or newly raised fault pins both motors in HOLD with a zero lockout count.
   assign hold_all = fault | inv | timeout;

   // Parameter sanity check on counter width.
   always_ff @(posedge clk) begin
      if (!rst) assert (CntWOk);
   end

   // Debounce: filtered value follows raw after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= '0;
         for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (raw[i] != filt_q[i]) begin
               if (deb_cnt_q[i] == DebLast) begin
                  filt_q[i]    <= raw[i];
                  deb_cnt_q[i] <= '0;
               end else begin
                  deb_cnt_q[i] <= deb_cnt_q[i] + One;
               end
            end else begin
               deb_cnt_q[i] <= '0;
            end
         end
      end
   end

`ifdef START_STAGGER_EN
   logic [CNT_W-1:0] stag_cnt_q;
   logic             m1_start;
   localparam logic [CNT_W-1:0] StagMax = CNT_W'(STAGGER);

   assign m1_start = !hold_all && (st1_q == StOff) && d1;
   assign m2_allow = !m1_start && (stag_cnt_q == StagMax);

   // Stagger counter: restarts on every m1 start, saturates at STAGGER.
   always_ff @(posedge clk) begin
      if (rst) begin
         stag_cnt_q <= StagMax;
      end else if (m1_start) begin
         stag_cnt_q <= '0;
      end else if (stag_cnt_q != StagMax) begin
         stag_cnt_q <= stag_cnt_q + One;
      end
   end
`else
   assign m2_allow = 1'b1;
`endif

   // Motor 1 FSM with registered contactor output.
   always_ff @(posedge clk) begin
      if (rst) begin
         st1_q      <= StOff;
         off_cnt1_q <= '0;
         m1         <= 1'b0;
      end else if (hold_all) begin
         st1_q      <= StHold;
         off_cnt1_q <= '0;
         m1         <= 1'b0;
      end else begin
         unique case (st1_q)
            StOff: begin
               if (d1) begin
                  st1_q <= StRun;
                  m1    <= 1'b1;
               end
            end
            StRun: begin
               if (!d1) begin
                  st1_q      <= StHold;
                  off_cnt1_q <= '0;
                  m1         <= 1'b0;
               end
            end
            StHold: begin
               if (off_cnt1_q == OffLast) begin
                  st1_q      <= StOff;
                  off_cnt1_q <= '0;
               end else begin
                  off_cnt1_q <= off_cnt1_q + One;
               end
            end
            default: begin
               st1_q <= StOff;
               m1    <= 1'b0;
            end
         endcase
      end
   end

   // Motor 2 FSM; d2 already drops when f1 = 0, which gives dry-run protection.
   always_ff @(posedge clk) begin
      if (rst) begin
         st2_q      <= StOff;
         off_cnt2_q <= '0;
         m2         <= 1'b0;
      end else if (hold_all) begin
         st2_q      <= StHold;
         off_cnt2_q <= '0;
         m2         <= 1'b0;
      end else begin
         unique case (st2_q)
            StOff: begin
               if (d2 && m2_allow) begin
                  st2_q <= StRun;
                  m2    <= 1'b1;
               end
            end
            StRun: begin
               if (!d2) begin
                  st2_q      <= StHold;
                  off_cnt2_q <= '0;
                  m2         <= 1'b0;
               end
            end
            StHold: begin
               if (off_cnt2_q == OffLast) begin
                  st2_q      <= StOff;
                  off_cnt2_q <= '0;
               end else begin
                  off_cnt2_q <= off_cnt2_q + One;
               end
            end
            default: begin
               st2_q <= StOff;
               m2    <= 1'b0;
            end
         endcase
      end
   end

   // Fill timer: counts edges spent with m1 in RUN, cleared otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt_q <= '0;
      end else if (st1_q == StRun) begin
         fill_cnt_q <= fill_cnt_q + One;
      end else begin
         fill_cnt_q <= '0;
      end
   end

   // Fault latch: first cause wins, inconsistency outranks timeout, clear needs ack and no inv.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault      <= 1'b0;
         fault_code <= 2'b00;
      end else if (fault) begin
         if (ack && !inv) begin
            fault      <= 1'b0;
            fault_code <= 2'b00;
         end
      end else if (inv) begin
         fault      <= 1'b1;
         fault_code <= 2'b01;
      end else if (timeout) begin
         fault      <= 1'b1;
         fault_code <= 2'b10;
      end
   end

endmodule

// File: tb/tb_sequenciador_bombas.sv
// Self-checking bench for sequenciador_bombas: table-driven main scenario plus
// hand-written sequences for start timing, dry-run protection and fault priority.
module tb_sequenciador_bombas;

   localparam int unsigned DEB_CYCLES = 4;
   localparam int unsigned MIN_OFF    = 8;
   localparam int unsigned MAX_FILL   = 20;
   localparam int unsigned STAGGER    = 4;
   localparam int NSTEPS = 24;
`ifdef START_STAGGER_EN
   localparam int M2_RISE = 6;
`else
   localparam int M2_RISE = 5;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0, ack = 1'b0;
   logic       m1, m2, fault;
   logic [1:0] fault_code;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       rst, s1, s2, s3, s4, ack;
      logic [7:0] n;
      logic       m1, m2, fault;
      logic [1:0] code;
   } step_t;

   step_t steps [NSTEPS];
   string names [NSTEPS];

   sequenciador_bombas #(
      .DEB_CYCLES(DEB_CYCLES),
      .MIN_OFF   (MIN_OFF),
      .MAX_FILL  (MAX_FILL),
      .STAGGER   (STAGGER),
      .CNT_W     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s1        (s1),
      .s2        (s2),
      .s3        (s3),
      .s4        (s4),
      .ack       (ack),
      .m1        (m1),
      .m2        (m2),
      .fault     (fault),
      .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   function automatic step_t mk(input logic r, input logic a, input logic b, input logic c,
                                input logic d, input logic k, input logic [7:0] n,
                                input logic e1, input logic e2, input logic ef,
                                input logic [1:0] ec);
      step_t s;
      s.rst = r; s.s1 = a; s.s2 = b; s.s3 = c; s.s4 = d; s.ack = k; s.n = n;
      s.m1 = e1; s.m2 = e2; s.fault = ef; s.code = ec;
      return s;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic e1, input logic e2, input logic ef,
                            input logic [1:0] ec);
      check({name, ".m1"}, int'(m1), int'(e1));
      check({name, ".m2"}, int'(m2), int'(e2));
      check({name, ".fault"}, int'(fault), int'(ef));
      check({name, ".code"}, int'(fault_code), int'(ec));
   endtask

   initial begin
      int e;
      int m1e;
      int m2e;

      //               rst s1 s2 s3 s4 ack  n  m1 m2 flt code
      steps[0]  = mk(1, 0, 0, 0, 0, 0, 2,  0, 0, 0, 2'b00); names[0]  = "reset";
      steps[1]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 2'b00); names[1]  = "first_edge";
      steps[2]  = mk(0, 1, 0, 0, 0, 0, 4,  1, 0, 0, 2'b00); names[2]  = "f1_debounce";
      steps[3]  = mk(0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 2'b00); names[3]  = "m2_start";
      steps[4]  = mk(0, 1, 1, 0, 0, 0, 4,  1, 1, 0, 2'b00); names[4]  = "f2_debounce";
      steps[5]  = mk(0, 1, 1, 0, 0, 0, 1,  0, 1, 0, 2'b00); names[5]  = "m1_stop";
      steps[6]  = mk(0, 1, 0, 0, 0, 0, 8,  0, 1, 0, 2'b00); names[6]  = "hold_lockout";
      steps[7]  = mk(0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 2'b00); names[7]  = "m1_restart";
      steps[8]  = mk(0, 1, 0, 0, 1, 0, 3,  1, 1, 0, 2'b00); names[8]  = "s4_glitch";
      steps[9]  = mk(0, 1, 0, 0, 0, 0, 3,  1, 1, 0, 2'b00); names[9]  = "glitch_rejected";
      steps[10] = mk(0, 0, 1, 0, 0, 0, 4,  1, 1, 0, 2'b00); names[10] = "inv_debounce";
      steps[11] = mk(0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 2'b01); names[11] = "inv_fault";
      steps[12] = mk(0, 0, 1, 0, 0, 1, 2,  0, 0, 1, 2'b01); names[12] = "ack_while_inv";
      steps[13] = mk(0, 0, 0, 0, 0, 0, 4,  0, 0, 1, 2'b01); names[13] = "inv_cleared";
      steps[14] = mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 2'b00); names[14] = "ack_clear";
      steps[15] = mk(0, 0, 0, 0, 0, 0, 8,  0, 0, 0, 2'b00); names[15] = "clear_lockout";
      steps[16] = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 2'b00); names[16] = "m1_after_clear";
      steps[17] = mk(0, 0, 0, 0, 0, 0, 19, 1, 0, 0, 2'b00); names[17] = "fill_running";
      steps[18] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 2'b10); names[18] = "fill_timeout";
      steps[19] = mk(0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 2'b00); names[19] = "timeout_ack";
      steps[20] = mk(0, 0, 0, 0, 0, 0, 8,  0, 0, 0, 2'b00); names[20] = "timeout_lockout";
      steps[21] = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 2'b00); names[21] = "m1_after_timeout";
      steps[22] = mk(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 2'b00); names[22] = "midop_reset";
      steps[23] = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 2'b00); names[23] = "reset_release";

      for (int i = 0; i < NSTEPS; i++) begin
         rst = steps[i].rst;
         s1  = steps[i].s1;
         s2  = steps[i].s2;
         s3  = steps[i].s3;
         s4  = steps[i].s4;
         ack = steps[i].ack;
         tick(int'(steps[i].n));
         check_all(names[i], steps[i].m1, steps[i].m2, steps[i].fault, steps[i].code);
      end

      // Both demands present from reset: record the edges where m1 and m2 first rise.
      rst = 1'b1; s1 = 1'b1; s2 = 1'b0; s3 = 1'b1; s4 = 1'b0; ack = 1'b0;
      tick(2);
      rst = 1'b0;
      e = 0; m1e = -1; m2e = -1;
      while (e < 40 && m2e < 0) begin
         tick(1);
         e++;
         if (m1 && m1e < 0) m1e = e;
         if (m2 && m2e < 0) m2e = e;
      end
      check("m1_rise_edge", m1e, 1);
      check("m2_rise_edge", m2e, M2_RISE);

      // Dry-run protection: losing the lower-tank low sensor stops m2 one edge after f1 drops.
      s1 = 1'b0;
      tick(4);
      check("dry_run_pre.m2", int'(m2), 1);
      tick(1);
      check("dry_run.m2", int'(m2), 0);
      check("dry_run.m1", int'(m1), 1);
      check("dry_run.fault", int'(fault), 0);

      // Upper-tank inconsistency raised on the same edge as the fill timeout: code 01 wins.
      rst = 1'b1; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(16);
      s4 = 1'b1;
      tick(4);
      check("prio_pre.m1", int'(m1), 1);
      check("prio_pre.fault", int'(fault), 0);
      tick(1);
      check("prio.fault", int'(fault), 1);
      check("prio.code", int'(fault_code), 1);
      check("prio.m1", int'(m1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
